// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: opcodes, CCR bit positions, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_pkg;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDM = 3'b001;
  localparam logic [2:0] OP_STD = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;
  localparam logic [2:0] OP_SHL = 3'b111;

  // CCR layout is {C,N,Z}
  localparam int CCR_Z = 0;
  localparam int CCR_N = 1;
  localparam int CCR_C = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operation/result handshake bundle for alu_seq plus CCR restore and busy status.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
// master: drives in_valid, alu_op, rs, rd, out_ready, ccr_we, ccr_in.
// slave : drives in_ready, out_valid, result, ccr, busy.
interface alu_seq_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rd;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [2:0]       ccr;
  logic             ccr_we;
  logic [2:0]       ccr_in;
  logic             busy;

  modport master (
    output in_valid, alu_op, rs, rd, out_ready, ccr_we, ccr_in,
    input  in_ready, out_valid, result, ccr, busy
  );

  modport slave (
    input  in_valid, alu_op, rs, rd, out_ready, ccr_we, ccr_in,
    output in_ready, out_valid, result, ccr, busy
  );

endinterface

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath: op, rs, rd -> result and flags with per-flag update enables.
// Latency: combinational.
// Backpressure: none (no state).
// Ports: op_i, rs_i, rd_i in; result_o, z_o, n_o, c_o, zn_valid_o, c_valid_o out.
module alu_comb #(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rd_i,
  output logic [WIDTH-1:0] result_o,
  output logic             z_o,
  output logic             n_o,
  output logic             c_o,
  output logic             zn_valid_o,
  output logic             c_valid_o
);
  import alu_pkg::*;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, rd_i} + {1'b0, rs_i};
  // rd + ~rs + 1: a carry-out means no borrow, so C is its inverse
  assign diff = {1'b0, rd_i} + {1'b0, ~rs_i} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    result_o   = '0;
    c_o        = 1'b0;
    zn_valid_o = 1'b0;
    c_valid_o  = 1'b0;
    case (op_i)
      OP_LDM: result_o = rd_i;
      OP_STD: result_o = rs_i;
      OP_ADD: begin
        result_o   = sum[WIDTH-1:0];
        c_o        = sum[WIDTH];
        zn_valid_o = 1'b1;
        c_valid_o  = 1'b1;
      end
      OP_NOT: begin
        result_o   = ~rd_i;
        zn_valid_o = 1'b1;
      end
      OP_SUB: begin
        result_o   = diff[WIDTH-1:0];
        c_o        = ~diff[WIDTH];
        zn_valid_o = 1'b1;
        c_valid_o  = 1'b1;
      end
      OP_AND: begin
        result_o   = rd_i & rs_i;
        zn_valid_o = 1'b1;
      end
      // Only the zero-amount shift completes here; longer shifts iterate in alu_seq
      OP_SHL: begin
        result_o   = rd_i;
        zn_valid_o = 1'b1;
      end
      default: result_o = '0;
    endcase
  end

  assign z_o = (result_o == '0);
  assign n_o = result_o[WIDTH-1];

endmodule

// File: rtl/alu_seq.sv
// Registered execute-stage ALU with CCR state, single-entry output buffer and iterative SHL.
// Latency: non-SHL 1 edge; SHL n>0 one accept edge plus ceil(n/STEP) shift edges.
// Backpressure: result held while out_valid & !out_ready; in_ready low during SHL and while stalled.
// Ports: clk, rst_n (sync, active low), bus (alu_seq_if.slave).
module alu_seq #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int STEP    = 1
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus
);
  import alu_pkg::*;

  // One extra bit so STEP == WIDTH is representable
  localparam int CNT_W = SHAMT_W + 1;

  state_t             state_q;
  logic [WIDTH-1:0]   result_q;
  logic [2:0]         ccr_q;
  logic [WIDTH-1:0]   acc_q;
  logic [CNT_W-1:0]   rem_q;

  logic               in_ready;
  logic               accept;
  logic [CNT_W-1:0]   shamt;
  logic [CNT_W-1:0]   step_amt;
  logic [CNT_W-1:0]   rem_d;
  logic [WIDTH-1:0]   acc_d;
  logic               cout_d;

  logic [WIDTH-1:0]   c_result;
  logic               c_z, c_n, c_c, c_zn_vld, c_c_vld;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .op_i       (bus.alu_op),
    .rs_i       (bus.rs),
    .rd_i       (bus.rd),
    .result_o   (c_result),
    .z_o        (c_z),
    .n_o        (c_n),
    .c_o        (c_c),
    .zn_valid_o (c_zn_vld),
    .c_valid_o  (c_c_vld)
  );

  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign shamt    = {1'b0, bus.rs[SHAMT_W-1:0]};

  // One shift step; the bit landing in position WIDTH is the last one shifted out
  always_comb begin
    step_amt        = (rem_q < CNT_W'(STEP)) ? rem_q : CNT_W'(STEP);
    {cout_d, acc_d} = {1'b0, acc_q} << step_amt;
    rem_d           = rem_q - step_amt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      ccr_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HOLD: begin
          if (accept) begin
            if ((bus.alu_op == OP_SHL) && (shamt != '0)) begin
              state_q <= ST_SHIFT;
              acc_q   <= bus.rd;
              rem_q   <= shamt;
            end else begin
              state_q  <= ST_HOLD;
              result_q <= c_result;
              if (c_zn_vld) begin
                ccr_q[CCR_Z] <= c_z;
                ccr_q[CCR_N] <= c_n;
              end
              if (c_c_vld) ccr_q[CCR_C] <= c_c;
            end
          end else if ((state_q == ST_HOLD) && bus.out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          acc_q <= acc_d;
          rem_q <= rem_d;
          if (rem_d == '0) begin
            state_q      <= ST_HOLD;
            result_q     <= acc_d;
            ccr_q[CCR_Z] <= (acc_d == '0);
            ccr_q[CCR_N] <= acc_d[WIDTH-1];
            ccr_q[CCR_C] <= cout_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      // Flag restore takes priority over any commit on the same edge
      if (bus.ccr_we) ccr_q <= bus.ccr_in;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.busy      = (state_q == ST_SHIFT);
  assign bus.result    = result_q;
  assign bus.ccr       = ccr_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: table of back-to-back ops plus hand-written multi-cycle sequences.
// Latency: n/a.
// Backpressure: exercised by stalling out_ready.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 16;
  localparam int NVEC = 14;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W), .SHAMT_W(4), .STEP(1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] rd;
    logic [W-1:0] rs;
    logic [W-1:0] res;
    logic [2:0]   ccr;
  } vec_t;

  vec_t vecs[NVEC];
  int   checks = 0;
  int   errors = 0;
  int   pulses;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [W-1:0] rd, input logic [W-1:0] rs);
    bus.in_valid = v;
    bus.alu_op   = op;
    bus.rd       = rd;
    bus.rs       = rs;
  endtask

  initial begin
    // ccr column is {C,N,Z}; flag-keeping rows depend on the row before
    vecs[0]  = '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 3'b101};
    vecs[1]  = '{OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 3'b110};
    vecs[2]  = '{OP_LDM, 16'h1234, 16'h0000, 16'h1234, 3'b110};
    vecs[3]  = '{OP_STD, 16'h0000, 16'hABCD, 16'hABCD, 3'b110};
    vecs[4]  = '{OP_NOP, 16'h5555, 16'h5555, 16'h0000, 3'b110};
    vecs[5]  = '{OP_AND, 16'hF0F0, 16'h0F0F, 16'h0000, 3'b101};
    vecs[6]  = '{OP_NOT, 16'h00FF, 16'h0000, 16'hFF00, 3'b110};
    vecs[7]  = '{OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 3'b010};
    vecs[8]  = '{OP_SUB, 16'h0005, 16'h0005, 16'h0000, 3'b001};
    vecs[9]  = '{OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 3'b110};
    vecs[10] = '{OP_SHL, 16'h1234, 16'h0000, 16'h1234, 3'b100};
    vecs[11] = '{OP_SHL, 16'h8000, 16'h0010, 16'h8000, 3'b110};
    vecs[12] = '{OP_AND, 16'hFFFF, 16'h8001, 16'h8001, 3'b110};
    vecs[13] = '{OP_ADD, 16'h8000, 16'h8000, 16'h0000, 3'b101};

    // Reset with an op offered
    rst_n         = 1'b0;
    bus.out_ready = 1'b1;
    bus.ccr_we    = 1'b0;
    bus.ccr_in    = 3'b000;
    drive(1'b1, OP_ADD, 16'hFFFF, 16'h0001);
    tick();
    tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", 32'(bus.result), 32'h0);
    check("rst_ccr", 32'(bus.ccr), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    drive(1'b0, OP_NOP, 16'h0, 16'h0);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("idle_out_valid", 32'(bus.out_valid), 32'd0);

    // Back-to-back table, one op per cycle
    for (int i = 0; i < NVEC; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].rd, vecs[i].rs);
      tick();
      check($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("vec%0d_result", i), 32'(bus.result), 32'(vecs[i].res));
      check($sformatf("vec%0d_ccr", i), 32'(bus.ccr), 32'(vecs[i].ccr));
      check($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
    end
    drive(1'b0, OP_NOP, 16'h0, 16'h0);
    tick();
    check("drain_out_valid", 32'(bus.out_valid), 32'd0);

    // SHL 8001 << 3: three busy cycles, inputs changed after accept
    drive(1'b1, OP_SHL, 16'h8001, 16'h0003);
    tick();
    drive(1'b0, OP_ADD, 16'hFFFF, 16'hFFFF);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("shl3_busy%0d", c), 32'(bus.busy), 32'd1);
      check($sformatf("shl3_in_ready%0d", c), 32'(bus.in_ready), 32'd0);
      check($sformatf("shl3_out_valid%0d", c), 32'(bus.out_valid), 32'd0);
      tick();
    end
    check("shl3_done_valid", 32'(bus.out_valid), 32'd1);
    check("shl3_done_busy", 32'(bus.busy), 32'd0);
    check("shl3_result", 32'(bus.result), 32'h0008);
    check("shl3_ccr", 32'(bus.ccr), 32'b000);
    tick();

    // SHL 4000 << 2: carry is the last bit out (bit 14), not the first
    drive(1'b1, OP_SHL, 16'h4000, 16'h0002);
    tick();
    drive(1'b0, OP_NOP, 16'h0, 16'h0);
    check("shl2_busy", 32'(bus.busy), 32'd1);
    tick();
    tick();
    check("shl2_out_valid", 32'(bus.out_valid), 32'd1);
    check("shl2_result", 32'(bus.result), 32'h0000);
    check("shl2_ccr", 32'(bus.ccr), 32'b101);
    tick();

    // Backpressure: ADD held for 5 cycles while AND waits
    bus.out_ready = 1'b0;
    drive(1'b1, OP_ADD, 16'h0003, 16'h0004);
    tick();
    drive(1'b1, OP_AND, 16'h00FF, 16'h0F0F);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_out_valid%0d", c), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp_result%0d", c), 32'(bus.result), 32'h0007);
      check($sformatf("bp_ccr%0d", c), 32'(bus.ccr), 32'b000);
      check($sformatf("bp_in_ready%0d", c), 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("bp_and_valid", 32'(bus.out_valid), 32'd1);
    check("bp_and_result", 32'(bus.result), 32'h000F);
    check("bp_and_ccr", 32'(bus.ccr), 32'b000);
    drive(1'b0, OP_NOP, 16'h0, 16'h0);
    tick();
    check("bp_idle_valid", 32'(bus.out_valid), 32'd0);

    // Flag restore on the commit edge wins, next NOT keeps the restored C
    drive(1'b1, OP_ADD, 16'h0003, 16'h0004);
    bus.ccr_we = 1'b1;
    bus.ccr_in = 3'b111;
    tick();
    bus.ccr_we = 1'b0;
    check("we_add_result", 32'(bus.result), 32'h0007);
    check("we_add_ccr", 32'(bus.ccr), 32'b111);
    drive(1'b1, OP_NOT, 16'h0000, 16'h0000);
    tick();
    check("we_not_result", 32'(bus.result), 32'hFFFF);
    check("we_not_ccr", 32'(bus.ccr), 32'b110);
    drive(1'b0, OP_NOP, 16'h0, 16'h0);
    tick();
    bus.ccr_we = 1'b1;
    bus.ccr_in = 3'b010;
    tick();
    bus.ccr_we = 1'b0;
    check("we_idle_ccr", 32'(bus.ccr), 32'b010);
    check("we_idle_valid", 32'(bus.out_valid), 32'd0);

    // Reset in the second cycle of a 5-bit shift
    drive(1'b1, OP_SHL, 16'h0001, 16'h0005);
    tick();
    drive(1'b0, OP_NOP, 16'h0, 16'h0);
    check("rsh_busy1", 32'(bus.busy), 32'd1);
    tick();
    check("rsh_busy2", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rsh_out_valid", 32'(bus.out_valid), 32'd0);
    check("rsh_busy", 32'(bus.busy), 32'd0);
    check("rsh_ccr", 32'(bus.ccr), 32'b000);
    check("rsh_result", 32'(bus.result), 32'h0);
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.out_valid) pulses++;
    end
    check("rsh_no_pulse", 32'(pulses), 32'd0);
    check("rsh_in_ready", 32'(bus.in_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
